// File: rtl/matmul_pkg.sv
// Shared types, defaults and saturation limits for the matmul MAC engine.
package matmul_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_ACC_W   = 64;
  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_DIM_W   = 10;
  localparam int DEF_MEM_LAT = 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    FINISH
  } state_e;

  function automatic longint sat_max(input int w);
    return (longint'(1) <<< (w - 1)) - longint'(1);
  endfunction

  function automatic longint sat_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

  localparam longint SAT_MAX = sat_max(DEF_DATA_W);
  localparam longint SAT_MIN = sat_min(DEF_DATA_W);

endpackage

// File: rtl/matmul_mac_engine_postproc.sv
// Bias add, arithmetic shift, ReLU and signed saturation of a dot product.
module matmul_postproc
  import matmul_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic signed [ACC_W-1:0] acc,
  input  logic                    bias_en,
  input  logic                    relu_en,
  input  logic [5:0]              shift,
  input  logic [DATA_W-1:0]       bias,
  output logic [DATA_W-1:0]       result
);

  localparam logic signed [ACC_W-1:0] HI =
    ACC_W'(sat_max(DATA_W));
  localparam logic signed [ACC_W-1:0] LO =
    ACC_W'(sat_min(DATA_W));

  logic signed [ACC_W-1:0] bias_ext;
  logic signed [ACC_W-1:0] biased;
  logic signed [ACC_W-1:0] shifted;
  logic signed [ACC_W-1:0] clamped;

  assign bias_ext = {{(ACC_W-DATA_W){bias[DATA_W-1]}}, bias};

  always_comb begin
    biased = acc;
    if (bias_en)
      biased = acc + bias_ext;
    shifted = biased >>> shift;
    clamped = shifted;
    if (relu_en && shifted[ACC_W-1])
      clamped = '0;
    if (clamped > HI)
      clamped = HI;
    else if (clamped < LO)
      clamped = LO;
    result = clamped[DATA_W-1:0];
  end

endmodule

// File: rtl/matmul_mac_engine.sv
// Streaming C = A*B MAC engine: one (i,j,p) read per cycle, one write per dot product.
module matmul_mac_engine
  import matmul_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ACC_W   = DEF_ACC_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DIM_W   = DEF_DIM_W,
  parameter int MEM_LAT = DEF_MEM_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              dim_err,
  input  logic [DIM_W-1:0]  m,
  input  logic [DIM_W-1:0]  n,
  input  logic [DIM_W-1:0]  k,
  input  logic              bias_en,
  input  logic              relu_en,
  input  logic [5:0]        shift,
  output logic [ADDR_W-1:0] input_addr,
  input  logic [DATA_W-1:0] input_data,
  output logic [ADDR_W-1:0] weight_addr,
  input  logic [DATA_W-1:0] weight_data,
  output logic [ADDR_W-1:0] bias_addr,
  input  logic [DATA_W-1:0] bias_data,
  output logic [ADDR_W-1:0] output_addr,
  output logic [DATA_W-1:0] output_data,
  output logic              write_enable
);

  localparam logic [MEM_LAT-1:0] TOP =
    MEM_LAT'(1) << (MEM_LAT - 1);

  state_e state, state_nxt;
  logic issue, fin, accept, dims_ok;
  logic [DIM_W-1:0] m_q, n_q, k_q;
  logic [DIM_W-1:0] i_q, j_q, p_q;
  logic bias_en_q, relu_en_q, err_q;
  logic [5:0] shift_q;
  logic [ADDR_W-1:0] row_base, oaddr_q;
  logic last_p, last_j, last_i, last_issue;
  logic drain_done;

  logic [MEM_LAT-1:0] pv, pf, pl;
  logic [ADDR_W-1:0]  po [MEM_LAT];
  logic bv, bf, bl;

  logic signed [ACC_W-1:0] a_ext, b_ext;
  logic signed [ACC_W-1:0] prod, acc_q, acc_sum;
  logic [DATA_W-1:0] result;

  assign dims_ok = (m != '0) && (n != '0) && (k != '0);
  assign accept  = (state == IDLE) && start;

  assign last_p = (p_q == k_q - DIM_W'(1));
  assign last_j = (j_q == n_q - DIM_W'(1));
  assign last_i = (i_q == m_q - DIM_W'(1));
  assign last_issue = last_p && last_j && last_i;

  // Only the final beat is left in flight once nothing else is valid.
  assign drain_done = (pv == TOP);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:
        if (start)
          state_nxt = dims_ok ? RUN : FINISH;
      RUN:
        if (last_issue) state_nxt = DRAIN;
      DRAIN:
        if (drain_done) state_nxt = FINISH;
      FINISH:
        state_nxt = IDLE;
      default:
        state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state != IDLE);
    issue = (state == RUN);
    fin   = (state == FINISH);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      done    <= 1'b0;
      dim_err <= 1'b0;
    end else begin
      done    <= fin;
      dim_err <= fin && err_q;
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_q       <= '0;
      n_q       <= '0;
      k_q       <= '0;
      bias_en_q <= 1'b0;
      relu_en_q <= 1'b0;
      shift_q   <= '0;
      err_q     <= 1'b0;
    end else if (accept) begin
      m_q       <= m;
      n_q       <= n;
      k_q       <= k;
      bias_en_q <= bias_en;
      relu_en_q <= relu_en;
      shift_q   <= shift;
      err_q     <= !dims_ok;
    end

  // Addresses advance incrementally; p innermost, then j, then i.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      i_q <= '0;
      j_q <= '0;
      p_q <= '0;
      row_base    <= '0;
      oaddr_q     <= '0;
      input_addr  <= '0;
      weight_addr <= '0;
      bias_addr   <= '0;
    end else if (accept) begin
      i_q <= '0;
      j_q <= '0;
      p_q <= '0;
      row_base    <= '0;
      oaddr_q     <= '0;
      input_addr  <= '0;
      weight_addr <= '0;
      bias_addr   <= '0;
    end else if (issue && !last_issue) begin
      if (!last_p) begin
        p_q <= p_q + DIM_W'(1);
        input_addr  <= input_addr + ADDR_W'(1);
        weight_addr <= weight_addr + ADDR_W'(n_q);
      end else begin
        p_q     <= '0;
        oaddr_q <= oaddr_q + ADDR_W'(1);
        if (!last_j) begin
          j_q <= j_q + DIM_W'(1);
          input_addr  <= row_base;
          weight_addr <= ADDR_W'(j_q + DIM_W'(1));
          bias_addr   <= ADDR_W'(j_q + DIM_W'(1));
        end else begin
          j_q <= '0;
          i_q <= i_q + DIM_W'(1);
          row_base    <= row_base + ADDR_W'(k_q);
          input_addr  <= row_base + ADDR_W'(k_q);
          weight_addr <= '0;
          bias_addr   <= '0;
        end
      end
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pv <= '0;
      pf <= '0;
      pl <= '0;
      for (int s = 0; s < MEM_LAT; s++)
        po[s] <= '0;
    end else begin
      pv[0] <= issue;
      pf[0] <= (p_q == '0);
      pl[0] <= last_p;
      po[0] <= oaddr_q;
      for (int s = 1; s < MEM_LAT; s++) begin
        pv[s] <= pv[s-1];
        pf[s] <= pf[s-1];
        pl[s] <= pl[s-1];
        po[s] <= po[s-1];
      end
    end

  assign bv = pv[MEM_LAT-1];
  assign bf = pf[MEM_LAT-1];
  assign bl = pl[MEM_LAT-1];

  assign a_ext = {{(ACC_W-DATA_W){input_data[DATA_W-1]}},
                  input_data};
  assign b_ext = {{(ACC_W-DATA_W){weight_data[DATA_W-1]}},
                  weight_data};
  assign prod    = a_ext * b_ext;
  assign acc_sum = bf ? prod : acc_q + prod;

  matmul_postproc #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_post (
    .acc     (acc_sum),
    .bias_en (bias_en_q),
    .relu_en (relu_en_q),
    .shift   (shift_q),
    .bias    (bias_data),
    .result  (result)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc_q        <= '0;
      write_enable <= 1'b0;
      output_addr  <= '0;
      output_data  <= '0;
    end else begin
      write_enable <= bv && bl;
      if (bv)
        acc_q <= acc_sum;
      if (bv && bl) begin
        output_addr <= po[MEM_LAT-1];
        output_data <= result;
      end
    end

endmodule

// File: tb/tb_matmul_mac_engine.sv
// Randomised and directed bench for matmul_mac_engine at MEM_LAT 1 and 3.
module tb_matmul_mac_engine;

  localparam int DW = 32;
  localparam int AW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [9:0] m = '0, n = '0, k = '0;
  logic bias_en = 1'b0, relu_en = 1'b0;
  logic [5:0] shift = '0;

  logic busy_v [2], done_v [2], err_v [2], we_v [2];
  logic [AW-1:0] ia_v [2], wa_v [2], ba_v [2], oa_v [2];
  logic [DW-1:0] od_v [2];

  logic signed [DW-1:0] amem [256];
  logic signed [DW-1:0] bmem [256];
  logic signed [DW-1:0] cmem [256];

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  int wcnt [2];
  int w_cyc [2][1024];
  logic [AW-1:0] w_addr [2][1024];
  logic [DW-1:0] w_data [2][1024];
  int dcnt [2];
  int d_cyc [2][256];
  logic d_err [2][256];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [DW-1:0] ap [LAT];
    logic [DW-1:0] bp [LAT];
    logic [DW-1:0] cp [LAT];

    always @(posedge clk) begin
      ap[0] <= amem[ia_v[g][7:0]];
      bp[0] <= bmem[wa_v[g][7:0]];
      cp[0] <= cmem[ba_v[g][7:0]];
      for (int s = 1; s < LAT; s++) begin
        ap[s] <= ap[s-1];
        bp[s] <= bp[s-1];
        cp[s] <= cp[s-1];
      end
    end

    matmul_mac_engine #(.MEM_LAT(LAT)) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .busy         (busy_v[g]),
      .done         (done_v[g]),
      .dim_err      (err_v[g]),
      .m            (m),
      .n            (n),
      .k            (k),
      .bias_en      (bias_en),
      .relu_en      (relu_en),
      .shift        (shift),
      .input_addr   (ia_v[g]),
      .input_data   (ap[LAT-1]),
      .weight_addr  (wa_v[g]),
      .weight_data  (bp[LAT-1]),
      .bias_addr    (ba_v[g]),
      .bias_data    (cp[LAT-1]),
      .output_addr  (oa_v[g]),
      .output_data  (od_v[g]),
      .write_enable (we_v[g])
    );
  end

  initial begin
    for (int g = 0; g < 2; g++) begin
      wcnt[g] = 0;
      dcnt[g] = 0;
    end
  end

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (we_v[g]) begin
        if (wcnt[g] < 1024) begin
          w_cyc[g][wcnt[g]]  <= cyc;
          w_addr[g][wcnt[g]] <= oa_v[g];
          w_data[g][wcnt[g]] <= od_v[g];
        end
        wcnt[g] <= wcnt[g] + 1;
      end
      if (done_v[g]) begin
        if (dcnt[g] < 256) begin
          d_cyc[g][dcnt[g]] <= cyc;
          d_err[g][dcnt[g]] <= err_v[g];
        end
        dcnt[g] <= dcnt[g] + 1;
      end
    end
  end

  task automatic chk(input string tag,
                     input longint got,
                     input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int lat_of(input int g);
    return (g == 0) ? 1 : 3;
  endfunction

  function automatic longint model(input int i, input int j,
                                   input int kk, input int nn,
                                   input int be, input int re,
                                   input int sh);
    longint acc = 0;
    for (int p = 0; p < kk; p++)
      acc += longint'(amem[i*kk+p]) * longint'(bmem[p*nn+j]);
    if (be != 0) acc += longint'(cmem[j]);
    acc = acc >>> sh;
    if (re != 0 && acc < 0) acc = 0;
    if (acc > 64'sd2147483647) acc = 64'sd2147483647;
    if (acc < -64'sd2147483648) acc = -64'sd2147483648;
    return acc;
  endfunction

  task automatic fill_rand();
    for (int a = 0; a < 64; a++) begin
      amem[a] = int'($urandom_range(65535)) - 32768;
      bmem[a] = int'($urandom_range(65535)) - 32768;
      cmem[a] = int'($urandom_range(65535)) - 32768;
    end
  endtask

  // Called right after a falling edge; returns one cycle past the window.
  task automatic run_job(input int mm, input int nn, input int kk,
                         input int be, input int re, input int sh,
                         input int intr);
    int c0, total, prods, nw, idx;
    int wb [2];
    int db [2];
    prods = mm * nn * kk;
    m = 10'(mm);
    n = 10'(nn);
    k = 10'(kk);
    bias_en = 1'(be);
    relu_en = 1'(re);
    shift = 6'(sh);
    for (int g = 0; g < 2; g++) begin
      wb[g] = wcnt[g];
      db[g] = dcnt[g];
    end
    c0 = cyc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int g = 0; g < 2; g++)
      chk($sformatf("g%0d_busy", g), longint'(busy_v[g]), 1);
    total = prods + 7;
    for (int t = 0; t < total; t++) begin
      @(negedge clk);
      if (intr > 0 && t == intr) begin
        start = 1'b1;
        m = 10'd1;
        n = 10'd1;
        k = 10'd1;
      end else begin
        start = 1'b0;
      end
    end
    #1;
    for (int g = 0; g < 2; g++) begin
      nw = wcnt[g] - wb[g];
      chk($sformatf("g%0d_ndone", g), dcnt[g] - db[g], 1);
      if (dcnt[g] > db[g] && db[g] < 256) begin
        chk($sformatf("g%0d_err", g), longint'(d_err[g][db[g]]),
            (prods == 0) ? 1 : 0);
        chk($sformatf("g%0d_done_cyc", g), d_cyc[g][db[g]] - c0,
            (prods == 0) ? 2 : prods + lat_of(g) + 2);
      end
      chk($sformatf("g%0d_nwr", g), nw, (prods == 0) ? 0 : mm*nn);
      for (int e = 0; e < mm*nn && e < nw && prods != 0; e++) begin
        idx = wb[g] + e;
        if (idx < 1024) begin
          chk($sformatf("g%0d_w%0d_addr", g, e),
              longint'(w_addr[g][idx]), e);
          chk($sformatf("g%0d_w%0d_data", g, e),
              longint'($signed(w_data[g][idx])),
              model(e / nn, e % nn, kk, nn, be, re, sh));
          chk($sformatf("g%0d_w%0d_cyc", g, e), w_cyc[g][idx] - c0,
              (e + 1) * kk + lat_of(g) + 1);
        end
      end
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("%s_g%0d_busy", tag, g), longint'(busy_v[g]), 0);
      chk($sformatf("%s_g%0d_done", tag, g), longint'(done_v[g]), 0);
      chk($sformatf("%s_g%0d_we", tag, g), longint'(we_v[g]), 0);
      chk($sformatf("%s_g%0d_ia", tag, g), longint'(ia_v[g]), 0);
      chk($sformatf("%s_g%0d_wa", tag, g), longint'(wa_v[g]), 0);
      chk($sformatf("%s_g%0d_oa", tag, g), longint'(oa_v[g]), 0);
      chk($sformatf("%s_g%0d_od", tag, g), longint'(od_v[g]), 0);
    end
  endtask

  initial begin
    int wb [2];
    int db [2];
    for (int a = 0; a < 256; a++) begin
      amem[a] = '0;
      bmem[a] = '0;
      cmem[a] = '0;
    end
    repeat (2) @(negedge clk);
    #1;
    chk_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 2x2 times identity
    amem[0] = 1; amem[1] = 2; amem[2] = 3; amem[3] = 4;
    bmem[0] = 1; bmem[1] = 0; bmem[2] = 0; bmem[3] = 1;
    run_job(2, 2, 2, 0, 0, 0, 0);
    chk("ident_w3_data", longint'($signed(w_data[0][3])), 4);

    amem[0] = -2; amem[1] = 3; amem[2] = -1;
    bmem[0] = 5; bmem[1] = -4; bmem[2] = 7;
    run_job(1, 1, 3, 0, 0, 0, 0);
    chk("dot_neg", longint'($signed(w_data[0][wcnt[0]-1])), -29);
    run_job(1, 1, 3, 0, 1, 0, 0);

    amem[0] = 32'sh7FFFFFFF;
    bmem[0] = 2;
    run_job(1, 1, 1, 0, 0, 0, 0);
    run_job(1, 1, 1, 0, 0, 1, 0);

    amem[0] = 1; amem[1] = 1;
    bmem[0] = 1; bmem[1] = 1; bmem[2] = 1;
    cmem[0] = 10; cmem[1] = 20; cmem[2] = 30;
    run_job(2, 3, 1, 1, 0, 0, 0);

    run_job(2, 2, 0, 0, 0, 0, 0);
    run_job(0, 3, 2, 1, 1, 0, 0);

    fill_rand();
    run_job(2, 2, 2, 1, 0, 2, 3);

    for (int r = 0; r < 10; r++) begin
      fill_rand();
      run_job($urandom_range(1, 3), $urandom_range(1, 3),
              $urandom_range(1, 4), $urandom_range(0, 1),
              $urandom_range(0, 1), $urandom_range(0, 4), 0);
    end

    // abort mid-run, then stay idle
    fill_rand();
    m = 10'd2; n = 10'd2; k = 10'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("abort");
    for (int g = 0; g < 2; g++) begin
      wb[g] = wcnt[g];
      db[g] = dcnt[g];
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    #1;
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("abort_g%0d_nwr", g), wcnt[g] - wb[g], 0);
      chk($sformatf("abort_g%0d_ndone", g), dcnt[g] - db[g], 0);
    end

    // abort again and restart on the first cycle out of reset
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    fill_rand();
    run_job(2, 2, 2, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/matmul_mac_engine.md
MATMUL_MAC_ENGINE -- requirements
Module: matmul_mac_engine

Interface
REQ-001 SHALL have parameter DATA_W, 32, operand/result width (signed two's complement).
REQ-002 SHALL have parameter ACC_W, 64, accumulator width, at least 2*DATA_W.
REQ-003 SHALL have parameter ADDR_W, 16, width of all memory address ports.
REQ-004 SHALL have parameter DIM_W, 10, width of m, n, k.
REQ-005 SHALL have parameter MEM_LAT, 1, read latency in cycles from address to data on all read ports, range 1..4.
REQ-006 SHALL use one clock and an asynchronous, active-low reset: clk, rst_n.
REQ-007 SHALL have ports clk in 1 (clock) and rst_n in 1 (async active-low reset).
REQ-008 SHALL have ports start in 1 (one-cycle request) and busy out 1 (high from the accepted start until done).
REQ-009 SHALL have ports done out 1 (one-cycle completion pulse) and dim_err out 1 (set with done when any dimension is 0).
REQ-010 SHALL have ports m, n, k in DIM_W each (rows of A, columns of B, inner dimension), sampled at start.
REQ-011 SHALL have ports bias_en, relu_en in 1 each, and shift in 6 (arithmetic right shift), all sampled at start.
REQ-012 SHALL have read ports input_addr out ADDR_W / input_data in DATA_W (A, row-major), weight_addr out ADDR_W / weight_data in DATA_W (B, row-major), and bias_addr out ADDR_W / bias_data in DATA_W (per column j).
REQ-013 SHALL have write port output_addr out ADDR_W, output_data out DATA_W, write_enable out 1 (C, row-major).

Function
REQ-014 SHALL implement states IDLE, RUN, DRAIN, FINISH; IDLE->RUN on start with all dims nonzero; RUN->DRAIN after the last address issue; DRAIN->FINISH after the last write; FINISH->IDLE after one cycle.
REQ-015 SHALL go IDLE->FINISH on start with any dim = 0, pulse done with dim_err=1, and issue no writes.
REQ-016 SHALL ignore start while busy.
REQ-017 SHALL issue one (i,j,p) address triple per RUN cycle with no wait cycles, p innermost, then j, then i: input_addr=i*k+p, weight_addr=p*n+j, bias_addr=j.
REQ-018 SHALL carry first/last/output_addr tags through a MEM_LAT-deep pipeline aligned with the returning data.
REQ-019 SHALL load the accumulator with the sign-extended product on a first-tagged beat and add it otherwise; back-to-back dot products SHALL NOT stall.
REQ-020 SHALL compute the result on a last-tagged beat as: acc (plus sign-extended bias_data if bias_en), arithmetic right shift by shift, clamp to 0 if relu_en and negative, saturate to the DATA_W signed range.
REQ-021 SHALL assert write_enable for exactly one cycle, one cycle after the last beat, with output_addr=i*n+j and output_data=result.
REQ-022 SHALL follow this timing, with start sampled at cycle 0: first issue at cycle 1, last issue at cycle m*n*k, last write at m*n*k+MEM_LAT+1, done at m*n*k+MEM_LAT+2.
REQ-023 SHALL allow k=1, in which every beat is both first and last, giving one write per cycle.
REQ-024 SHALL keep address arithmetic modulo 2^ADDR_W; out-of-range products are the caller's responsibility.

Reset
REQ-025 SHALL on rst_n low, asynchronously, force state IDLE and set busy, done, dim_err, write_enable, input_addr, weight_addr, bias_addr, output_addr, output_data and the accumulator to 0.
REQ-026 SHALL, after reset mid-operation, issue no further writes and accept a new start on the first cycle after rst_n deasserts.

Structure
REQ-027 SHALL place the state enum, the default parameter values and the saturation limit constants in shared package matmul_pkg.
REQ-028 SHALL implement the bias/shift/ReLU/saturate path in sub-module matmul_postproc (combinational or one register stage, latency included in REQ-022).

Verification
REQ-029 SHALL cover: m=n=k=2, A=[[1,2],[3,4]], B=identity, MEM_LAT=1 -> writes addr0..3 = 1,2,3,4; done at cycle 11.
REQ-030 SHALL cover: m=n=1, k=3, A=[-2,3,-1], B=[5,-4,7] -> output_data=-29; with relu_en=1 -> 0.
REQ-031 SHALL cover: m=n=k=1, A=0x7FFFFFFF, B=2, shift=0 -> output_data=0x7FFFFFFF (saturated); with shift=1 -> 0x7FFFFFFF exact.
REQ-032 SHALL cover: m=2, n=3, k=1, bias_en=1, bias=[10,20,30], all A=B=1 -> outputs 11,21,31,11,21,31 on consecutive cycles.
REQ-033 SHALL cover: k=0 -> done plus dim_err two cycles after start, no write_enable; start while busy -> ignored.
REQ-034 SHALL cover: MEM_LAT=3, then rst_n pulsed mid-RUN -> no writes after reset, and a fresh 2x2x2 run is correct.
